// File: rtl/t_pkg.sv
// Shared definitions for the T flip-flop button debouncer: FSM state
// encoding and default timing parameters.
package t_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  localparam int unsigned DB_CYCLES_DEF  = 4;
  localparam int unsigned REP_CYCLES_DEF = 0;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing the asynchronous button level into the c domain.
module sync2 (
  input  logic c,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/t_debounce.sv
// Push-button debouncer producing one-cycle toggle requests for a downstream
// T flip-flop, with optional held-press auto-repeat and a pulse counter.
module t_debounce
  import t_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = DB_CYCLES_DEF,
  parameter int unsigned REP_CYCLES = REP_CYCLES_DEF
) (
  input  logic       c,
  input  logic       rst_n,
  input  logic       btn,
  output logic       t,
  output logic       pressed,
  output logic [7:0] tcnt
);

  localparam logic [7:0]  DB_LAST  = 8'(DB_CYCLES - 1);
  localparam logic [15:0] REP_LAST = 16'(REP_CYCLES - 1);
  localparam bit          REP_EN   = (REP_CYCLES != 0);

  logic        s2;
  state_t      state, state_d;
  logic [7:0]  dcnt, dcnt_d;
  logic [15:0] rcnt, rcnt_d;
  logic        t_d;
  logic        pressed_d;
  logic [7:0]  tcnt_d;

  sync2 u_sync (
    .c     (c),
    .rst_n (rst_n),
    .d     (btn),
    .q     (s2)
  );

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dcnt    <= '0;
      rcnt    <= '0;
      t       <= 1'b0;
      pressed <= 1'b0;
      tcnt    <= '0;
    end else begin
      state   <= state_d;
      dcnt    <= dcnt_d;
      rcnt    <= rcnt_d;
      t       <= t_d;
      pressed <= pressed_d;
      tcnt    <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state;
    dcnt_d  = dcnt;
    rcnt_d  = rcnt;
    t_d     = 1'b0;
    tcnt_d  = tcnt;

    case (state)
      IDLE: begin
        if (s2) begin
          state_d = DEB_PRESS;
          dcnt_d  = '0;
        end
      end

      DEB_PRESS: begin
        if (!s2) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dcnt == DB_LAST) begin
          state_d = HELD;
          dcnt_d  = '0;
          rcnt_d  = '0;
          t_d     = 1'b1;
        end else begin
          dcnt_d = dcnt + 8'd1;
        end
      end

      HELD: begin
        if (!s2) begin
          state_d = DEB_REL;
          dcnt_d  = '0;
        end else if (REP_EN) begin
          // Gating on the current t keeps pulses separated even at REP_CYCLES=1.
          if (rcnt == REP_LAST) begin
            rcnt_d = '0;
            t_d    = !t;
          end else begin
            rcnt_d = rcnt + 16'd1;
          end
        end else begin
          rcnt_d = '0;
        end
      end

      DEB_REL: begin
        if (s2) begin
          state_d = HELD;
          rcnt_d  = '0;
        end else if (dcnt == DB_LAST) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        dcnt_d  = '0;
        rcnt_d  = '0;
      end
    endcase

    if (t_d) tcnt_d = tcnt + 8'd1;
    pressed_d = (state_d == HELD) || (state_d == DEB_REL);
  end

endmodule

// File: tb/tb_t_debounce.sv
// Bench for t_debounce: two instances (no repeat / 8-cycle repeat) on shared
// stimulus, checked every cycle against a run-length model plus literal checks.
module tb_t_debounce;

  localparam int unsigned DB_A  = 4;
  localparam int unsigned REP_A = 0;
  localparam int unsigned DB_B  = 4;
  localparam int unsigned REP_B = 8;

  logic       c;
  logic       rst_n;
  logic       btn;
  logic       t_a, t_b;
  logic       pressed_a, pressed_b;
  logic [7:0] tcnt_a, tcnt_b;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses_a = 0;

  t_debounce #(.DB_CYCLES(DB_A), .REP_CYCLES(REP_A)) dut_a (
    .c(c), .rst_n(rst_n), .btn(btn), .t(t_a), .pressed(pressed_a), .tcnt(tcnt_a)
  );

  t_debounce #(.DB_CYCLES(DB_B), .REP_CYCLES(REP_B)) dut_b (
    .c(c), .rst_n(rst_n), .btn(btn), .t(t_b), .pressed(pressed_b), .tcnt(tcnt_b)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the debounced level flips after DB+1 consecutive synchronized
  // samples of the opposite level; repeat phase counts held cycles.
  bit          h1 = 1'b0, h2 = 1'b0;
  int unsigned m_run[2] = '{0, 0};
  int unsigned m_ph[2]  = '{0, 0};
  bit          m_p[2]   = '{1'b0, 1'b0};
  bit          m_t[2]   = '{1'b0, 1'b0};
  bit [7:0]    m_cnt[2] = '{8'd0, 8'd0};

  initial begin : model
    bit s;
    bit tn;
    int unsigned db, rep;
    forever begin
      @(posedge c or negedge rst_n);
      if (!rst_n) begin
        h1 = 1'b0;
        h2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
          m_run[k] = 0; m_ph[k] = 0; m_p[k] = 1'b0; m_t[k] = 1'b0; m_cnt[k] = 8'd0;
        end
      end else begin
        s  = h2;
        h2 = h1;
        h1 = btn;
        for (int k = 0; k < 2; k++) begin
          db  = (k == 0) ? DB_A : DB_B;
          rep = (k == 0) ? REP_A : REP_B;
          tn  = 1'b0;
          if (!m_p[k]) begin
            if (s) begin
              m_run[k]++;
              if (m_run[k] == db + 1) begin
                m_p[k] = 1'b1; tn = 1'b1; m_run[k] = 0; m_ph[k] = 0;
              end
            end else begin
              m_run[k] = 0;
            end
          end else if (!s) begin
            m_run[k]++;
            if (m_run[k] == db + 1) begin
              m_p[k] = 1'b0; m_run[k] = 0;
            end
          end else if (m_run[k] != 0) begin
            m_run[k] = 0;
            m_ph[k]  = 0;
          end else if (rep != 0) begin
            m_ph[k]++;
            if (m_ph[k] == rep) begin
              m_ph[k] = 0;
              tn = !m_t[k];
            end
          end
          m_t[k] = tn;
          if (tn) m_cnt[k] = m_cnt[k] + 8'd1;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge c);
      check("a_t",       int'(t_a),       int'(m_t[0]));
      check("a_pressed", int'(pressed_a), int'(m_p[0]));
      check("a_tcnt",    int'(tcnt_a),    int'(m_cnt[0]));
      check("b_t",       int'(t_b),       int'(m_t[1]));
      check("b_pressed", int'(pressed_b), int'(m_p[1]));
      check("b_tcnt",    int'(tcnt_b),    int'(m_cnt[1]));
      if (t_a === 1'b1) pulses_a++;
    end
  end

  initial begin : stim
    int base_cnt;
    int base_pulses;
    int found;
    int exp_b;
    rst_n = 1'b0;
    btn   = 1'b0;
    repeat (3) @(negedge c);
    check("rst_t",       int'(t_a),       0);
    check("rst_pressed", int'(pressed_a), 0);
    check("rst_tcnt",    int'(tcnt_a),    0);
    check("rst_tcnt_b",  int'(tcnt_b),    0);
    rst_n = 1'b1;
    repeat (2) @(negedge c);

    // Clean press held 40 cycles; edge 0 is the first edge after btn rises.
    btn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge c);
      #1;
      exp_b = (i == 6 || i == 14 || i == 22 || i == 30 || i == 38) ? 1 : 0;
      check("press_t_a",       int'(t_a),       int'(i == 6));
      check("press_t_b",       int'(t_b),       exp_b);
      check("press_pressed_a", int'(pressed_a), int'(i >= 6));
    end
    check("press_tcnt_a", int'(tcnt_a), 1);
    check("press_tcnt_b", int'(tcnt_b), 5);

    // Two-cycle release glitch while held.
    @(negedge c) btn = 1'b0;
    @(negedge c);
    @(negedge c) btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge c);
      check("glitch_pressed_a", int'(pressed_a), 1);
      check("glitch_t_a",       int'(t_a),       0);
    end
    btn = 1'b0;
    repeat (12) @(negedge c);
    check("release_pressed_a", int'(pressed_a), 0);
    check("release_tcnt_a",    int'(tcnt_a),    1);

    // Bounce 1,0,1,0 then hold low.
    base_cnt = int'(tcnt_a);
    btn = 1'b1; @(negedge c);
    btn = 1'b0; @(negedge c);
    btn = 1'b1; @(negedge c);
    btn = 1'b0;
    repeat (10) @(negedge c);
    check("bounce_tcnt_a",    int'(tcnt_a),    base_cnt);
    check("bounce_pressed_a", int'(pressed_a), 0);

    // 256 full presses wrap tcnt.
    base_cnt    = int'(tcnt_a);
    base_pulses = pulses_a;
    for (int n = 0; n < 256; n++) begin
      btn = 1'b1;
      repeat (8) @(negedge c);
      btn = 1'b0;
      repeat (8) @(negedge c);
    end
    check("wrap_tcnt_a",   int'(tcnt_a),           base_cnt);
    check("wrap_pulses_a", pulses_a - base_pulses, 256);

    // Reset during a t pulse, then re-debounce with btn still high.
    btn = 1'b1;
    found = -1;
    for (int i = 0; i < 20 && found < 0; i++) begin
      @(posedge c);
      #1;
      if (t_a === 1'b1) found = i;
    end
    check("pulse_before_reset", found, 6);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_t",       int'(t_a),       0);
    check("async_rst_pressed", int'(pressed_a), 0);
    check("async_rst_tcnt",    int'(tcnt_a),    0);
    check("async_rst_tcnt_b",  int'(tcnt_b),    0);
    @(negedge c) rst_n = 1'b1;
    found = -1;
    for (int i = 0; i < 20 && found < 0; i++) begin
      @(posedge c);
      #1;
      if (t_a === 1'b1) found = i;
    end
    check("pulse_after_reset", found, int'(DB_A) + 2);
    @(negedge c) btn = 1'b0;
    repeat (10) @(negedge c);

    // Random runs of levels with occasional resets.
    for (int seg = 0; seg < 400; seg++) begin
      btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) rst_n = 1'b0;
      @(negedge c);
      rst_n = 1'b1;
      repeat ($urandom_range(0, (seg % 4 == 0) ? 30 : 8)) @(negedge c);
    end
    btn = 1'b0;
    repeat (12) @(negedge c);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
